pong_game_ctrl: RTL and testbench

Game-sequencing controller for the two-player pong display. It owns the match state machine and freezes or releases the graphics engine through `gra_still`. It consumes the graphics engine's `miss`/`hit` outcome to keep two-digit BCD scores per player, times the serve and game-over pauses in video frames, and declares a winner. It sits between the button inputs, the VGA sync counters and the graphics engine, and its score and state outputs feed the text and score overlay.

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/bcd2_counter.sv | 33 +++
 rtl/pong_game_ctrl.sv | 129 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types, constants and BCD helpers for the pong game sequencer.
package pong_pkg;

  typedef enum logic [1:0] {
    StNewGame = 2'd0,
    StPlay    = 2'd1,
    StNewBall = 2'd2,
    StOver    = 2'd3
  } state_e;

  localparam logic [9:0] TICK_X = 10'd0;
  localparam logic [9:0] TICK_Y = 10'd481;

  // Winner codes share the encoding of the hit side that earns the point.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else if (v[7:4] != 4'd9) begin
      r[7:4] = v[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter with synchronous clear, saturating at 99.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] dig
);

  logic [7:0] dig_q, dig_d;

  always_comb begin
    dig_d = dig_q;
    if (clr) begin
      dig_d = 8'h00;
    end else if (inc) begin
      dig_d = bcd_inc(dig_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_q <= 8'h00;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign dig = dig_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: start/serve/game-over pauses, BCD scoring and winner detection.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       miss,
  input  logic [1:0] hit,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic [1:0] winner
);

  localparam logic [7:0] WinBcd    = to_bcd(WIN_SCORE);
  localparam logic [7:0] ServeLoad = 8'(SERVE_FRAMES);
  localparam logic [7:0] OverLoad  = 8'(OVER_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] btn_prev_q;
  logic [1:0] winner_q, winner_d;
  logic       still_q, still_d;

  logic       tick, start;
  logic       clr, inc_l, inc_r, won;
  logic [7:0] next_l, next_r;

  assign tick   = (x == TICK_X) && (y == TICK_Y);
  assign start  = (btn != 4'h0) && (btn_prev_q == 4'h0);
  assign next_l = bcd_inc(score_l);
  assign next_r = bcd_inc(score_r);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    winner_d = winner_q;
    clr      = 1'b0;
    inc_l    = 1'b0;
    inc_r    = 1'b0;
    won      = 1'b0;
    unique case (state_q)
      StNewGame: begin
        // Scores of the finished match stay visible until the next start.
        if (start) begin
          clr      = 1'b1;
          winner_d = WIN_NONE;
          state_d  = StPlay;
        end
      end
      StPlay: begin
        if (miss) begin
          if (hit == WIN_L) begin
            inc_l = 1'b1;
            won   = (next_l == WinBcd);
          end else if (hit == WIN_R) begin
            inc_r = 1'b1;
            won   = (next_r == WinBcd);
          end
          if (won) begin
            winner_d = hit;
            timer_d  = OverLoad;
            state_d  = StOver;
          end else begin
            timer_d  = ServeLoad;
            state_d  = StNewBall;
          end
        end
      end
      StNewBall, StOver: begin
        if (tick) begin
          if (timer_q == 8'd1) begin
            timer_d = 8'd0;
            state_d = (state_q == StNewBall) ? StPlay : StNewGame;
          end else if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: state_d = StNewGame;
    endcase
    still_d = (state_d != StPlay);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StNewGame;
      timer_q    <= 8'd0;
      btn_prev_q <= 4'hF;
      winner_q   <= WIN_NONE;
      still_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      btn_prev_q <= btn;
      winner_q   <= winner_d;
      still_q    <= still_d;
    end
  end

  bcd2_counter u_score_l (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (inc_l),
    .dig     (score_l)
  );

  bcd2_counter u_score_r (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (inc_r),
    .dig     (score_r)
  );

  assign gra_still  = still_q;
  assign game_state = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, scoreboard queue, multi-cycle sequences.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] btn = 4'h1;
  logic [9:0] x = 10'd100;
  logic [9:0] y = 10'd100;
  logic       miss_a = 1'b0;
  logic       miss_b = 1'b0;
  logic [1:0] hit = 2'b00;

  logic       still_a, still_b;
  logic [1:0] gs_a, gs_b, win_a, win_b;
  logic [7:0] sl_a, sr_a, sl_b, sr_b;
  logic [20:0] act_a, act_b;

  assign act_a = {gs_a, still_a, sl_a, sr_a, win_a};
  assign act_b = {gs_b, still_b, sl_b, sr_b, win_b};

  always #5 clk = ~clk;

  pong_game_ctrl #(.WIN_SCORE(5), .SERVE_FRAMES(120), .OVER_FRAMES(180)) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .x(x), .y(y), .miss(miss_a), .hit(hit),
    .gra_still(still_a), .game_state(gs_a), .score_l(sl_a), .score_r(sr_a), .winner(win_a)
  );

  pong_game_ctrl #(.WIN_SCORE(15), .SERVE_FRAMES(2), .OVER_FRAMES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .btn(btn), .x(x), .y(y), .miss(miss_b), .hit(hit),
    .gra_still(still_b), .game_state(gs_b), .score_l(sl_b), .score_r(sr_b), .winner(win_b)
  );

  typedef struct {
    string       name;
    logic [3:0]  btn;
    logic        miss;
    logic [1:0]  hit;
    logic        tick;
    logic [20:0] exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] sb_q[$];
  string       nm_q[$];
  vec_t        tbl[10];

  function automatic logic [20:0] pk(input logic [1:0] st, input logic s, input logic [7:0] l,
                                     input logic [7:0] r, input logic [1:0] w);
    return {st, s, l, r, w};
  endfunction

  function automatic logic [7:0] model_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
    else if (v[7:4] != 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  task automatic check(input string nm, input logic [20:0] act, input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d still=%0d sl=%h sr=%h win=%b, want st=%0d still=%0d sl=%h sr=%h win=%b",
               nm, act[20:19], act[18], act[17:10], act[9:2], act[1:0],
               exp[20:19], exp[18], exp[17:10], exp[9:2], exp[1:0]);
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic m, input logic [1:0] h, input logic t);
    btn    = b;
    miss_a = m;
    hit    = h;
    x      = t ? 10'd0 : 10'd100;
    y      = t ? 10'd481 : 10'd100;
  endtask

  task automatic cycle(input string nm, input logic [3:0] b, input logic m, input logic [1:0] h,
                       input logic t, input logic [20:0] e);
    @(negedge clk);
    drive(b, m, h, t);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check(nm_q.pop_front(), act_a, sb_q.pop_front());
  endtask

  // n frame ticks separated by idle cycles; state must hold until the n-th tick.
  task automatic ticks(input string nm, input int n, input logic [20:0] during,
                       input logic [20:0] after);
    for (int i = 0; i < n; i++) begin
      cycle(nm, 4'h0, 1'b0, 2'b00, 1'b1, (i == n - 1) ? after : during);
      if (i != n - 1) cycle(nm, 4'h0, 1'b0, 2'b00, 1'b0, during);
    end
  endtask

  initial begin
    logic [7:0] sr_m;

    tbl[0] = '{"held_after_reset0", 4'h1, 1'b0, 2'b00, 1'b0, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00)};
    tbl[1] = '{"held_after_reset1", 4'h1, 1'b0, 2'b00, 1'b0, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00)};
    tbl[2] = '{"release",           4'h0, 1'b0, 2'b00, 1'b0, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00)};
    tbl[3] = '{"press_start",       4'h2, 1'b0, 2'b00, 1'b0, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00)};
    tbl[4] = '{"press_held",        4'h2, 1'b0, 2'b00, 1'b0, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00)};
    tbl[5] = '{"tick_in_play",      4'h0, 1'b0, 2'b00, 1'b1, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00)};
    tbl[6] = '{"miss_left",         4'h0, 1'b1, 2'b10, 1'b0, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00)};
    tbl[7] = '{"miss_held",         4'h0, 1'b1, 2'b10, 1'b0, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00)};
    tbl[8] = '{"start_in_newball",  4'h1, 1'b0, 2'b00, 1'b0, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00)};
    tbl[9] = '{"first_serve_tick",  4'h0, 1'b0, 2'b00, 1'b1, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00)};

    // Reset asserted between edges with a button held.
    #2 reset_n = 1'b0;
    #1 check("reset_async", act_a, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00));
    repeat (2) @(posedge clk);
    #1 check("reset_held", act_a, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].name, tbl[i].btn, tbl[i].miss, tbl[i].hit, tbl[i].tick, tbl[i].exp);
    end

    ticks("serve1", 119, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00), pk(2'd1, 1'b0, 8'h01, 8'h00, 2'b00));

    cycle("hit11_no_score", 4'h0, 1'b1, 2'b11, 1'b0, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00));
    ticks("serve2", 120, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00), pk(2'd1, 1'b0, 8'h01, 8'h00, 2'b00));

    // A tick on the miss cycle must not shorten the pause.
    cycle("miss_r_on_tick", 4'h0, 1'b1, 2'b01, 1'b1, pk(2'd2, 1'b1, 8'h01, 8'h01, 2'b00));
    ticks("serve3", 120, pk(2'd2, 1'b1, 8'h01, 8'h01, 2'b00), pk(2'd1, 1'b0, 8'h01, 8'h01, 2'b00));

    sr_m = 8'h01;
    for (int k = 2; k <= 4; k++) begin
      sr_m = model_inc(sr_m);
      cycle("miss_r", 4'h0, 1'b1, 2'b01, 1'b0, pk(2'd2, 1'b1, 8'h01, sr_m, 2'b00));
      ticks("serve_r", 120, pk(2'd2, 1'b1, 8'h01, sr_m, 2'b00), pk(2'd1, 1'b0, 8'h01, sr_m, 2'b00));
    end

    cycle("win_right", 4'h0, 1'b1, 2'b01, 1'b0, pk(2'd3, 1'b1, 8'h01, 8'h05, 2'b01));
    cycle("miss_in_over", 4'h0, 1'b1, 2'b10, 1'b0, pk(2'd3, 1'b1, 8'h01, 8'h05, 2'b01));
    cycle("start_in_over", 4'h4, 1'b0, 2'b00, 1'b0, pk(2'd3, 1'b1, 8'h01, 8'h05, 2'b01));
    ticks("over", 180, pk(2'd3, 1'b1, 8'h01, 8'h05, 2'b01), pk(2'd0, 1'b1, 8'h01, 8'h05, 2'b01));
    cycle("newgame_idle", 4'h0, 1'b0, 2'b00, 1'b0, pk(2'd0, 1'b1, 8'h01, 8'h05, 2'b01));
    cycle("restart_clears", 4'h2, 1'b0, 2'b00, 1'b0, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00));

    cycle("miss_before_rst", 4'h0, 1'b1, 2'b10, 1'b0, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00));
    cycle("tick_before_rst", 4'h0, 1'b0, 2'b00, 1'b1, pk(2'd2, 1'b1, 8'h01, 8'h00, 2'b00));
    #2 reset_n = 1'b0;
    #1 check("reset_mid_newball", act_a, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00));
    check("reset_mid_b", act_b, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00));
    @(negedge clk);
    reset_n = 1'b1;
    cycle("post_rst_idle", 4'h0, 1'b0, 2'b00, 1'b0, pk(2'd0, 1'b1, 8'h00, 8'h00, 2'b00));
    cycle("post_rst_start", 4'h8, 1'b0, 2'b00, 1'b0, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00));
    check("b_started", act_b, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00));

    // Second instance (WIN_SCORE=15): ten right-side points exercise the BCD carry.
    sr_m = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive(4'h0, 1'b0, 2'b01, 1'b0);
      miss_b = 1'b1;
      @(posedge clk);
      #1;
      sr_m = model_inc(sr_m);
      check("b_miss_r", act_b, pk(2'd2, 1'b1, 8'h00, sr_m, 2'b00));
      @(negedge clk);
      miss_b = 1'b0;
      ticks("b_serve_main", 2, pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00),
            pk(2'd1, 1'b0, 8'h00, 8'h00, 2'b00));
      check("b_serve", act_b, pk(2'd1, 1'b0, 8'h00, sr_m, 2'b00));
    end
    check("b_bcd_carry", act_b, pk(2'd1, 1'b0, 8'h00, 8'h10, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
